// File: rtl/fetch_queue.sv
//------------------------------------------------------------------------------
// fetch_queue : PC owner, ROM fetch and DEPTH-entry {pc, pc+4, ins} FIFO for decode.
// Optional same-cycle bypass when the queue is empty: define FETCHQ_BYPASS_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_data,
  input  logic                       imem_valid,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [31:0]                deq_ins,
  output logic [31:0]                deq_pc,
  output logic [31:0]                deq_pc4,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [95:0]   mem [DEPTH];

  logic bypass;
  logic deq_fire;
  logic fifo_deq;
  logic fetch;
  logic enq;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = {1'b0, pc[30:0]};

`ifdef FETCHQ_BYPASS_EN
  assign bypass = (count == '0) && imem_valid && !redirect;
`else
  assign bypass = 1'b0;
`endif

  assign deq_valid = (count != '0) || bypass;
  assign deq_fire  = deq_valid && deq_ready && !redirect;
  assign fifo_deq  = deq_fire && !bypass;
  // A fetch advances the PC whether the word lands in the FIFO or is consumed by bypass.
  assign fetch     = imem_valid && !redirect && ((count < FULL_COUNT) || fifo_deq);
  assign enq       = fetch && !(bypass && deq_ready);

  always_comb begin
    deq_ins = 32'd0;
    deq_pc  = {pc[31], 31'd0};
    deq_pc4 = {pc[31], 31'd0};
    if (bypass) begin
      deq_ins = imem_data;
      deq_pc  = pc;
      deq_pc4 = pc_plus4;
    end else if (count != '0) begin
      deq_pc  = mem[head][95:64];
      deq_pc4 = mem[head][63:32];
      deq_ins = mem[head][31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem[tail] <= {pc, pc_plus4, imem_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      pc    <= {redirect_pc[31:2], 2'b00};
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (fetch) begin
        pc <= pc_plus4;
      end
      if (enq) begin
        tail <= tail + 1'b1;
      end
      if (fifo_deq) begin
        head <= head + 1'b1;
      end
      case ({enq, fifo_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4, RESET_PC=0, bypass disabled).
`default_nettype none

module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_valid;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_ins;
  logic [31:0] deq_pc;
  logic [31:0] deq_pc4;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .imem_valid (imem_valid),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .deq_valid  (deq_valid),
    .deq_ready  (deq_ready),
    .deq_ins    (deq_ins),
    .deq_pc     (deq_pc),
    .deq_pc4    (deq_pc4),
    .count      (count)
  );

  always #5 clk = ~clk;

  // ROM: word at address A is 0x24080000 + A
  assign imem_data = 32'h2408_0000 + imem_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(deq_valid), 32'd1);
    chk({tag, "_pc"},    deq_pc,         pc);
    chk({tag, "_pc4"},   deq_pc4,        pc + 32'd4);
    chk({tag, "_ins"},   deq_ins,        32'h2408_0000 + {1'b0, pc[30:0]});
  endtask

  task automatic chk_bubble(input string tag, input logic [31:0] bpc);
    chk({tag, "_valid"}, 32'(deq_valid), 32'd0);
    chk({tag, "_pc"},    deq_pc,         bpc);
    chk({tag, "_pc4"},   deq_pc4,        bpc);
    chk({tag, "_ins"},   deq_ins,        32'd0);
    chk({tag, "_count"}, 32'(count),     32'd0);
  endtask

  initial begin
    reset       = 1'b0;
    imem_valid  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    deq_ready   = 1'b0;
    #1;
    chk_bubble("rst", 32'h0000_0000);
    chk("rst_addr", imem_addr, 32'h0000_0000);
    tick();
    tick();

    // Backpressure from reset: fill to DEPTH and hold PC at 0x10
    reset      = 1'b1;
    imem_valid = 1'b1;
    deq_ready  = 1'b0;
    for (int j = 0; j < 10; j++) begin
      #1;
      chk("fill_count", 32'(count),  (j < 4) ? 32'(j) : 32'd4);
      chk("fill_addr",  imem_addr,   (j < 4) ? 32'(4 * j) : 32'h10);
      tick();
    end

    // Release while full: one dequeue and one enqueue per cycle, count stays 4
    deq_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      #1;
      chk_head("drain", 32'(4 * r));
      chk("drain_count", 32'(count), 32'd4);
      chk("drain_addr",  imem_addr,  32'(16 + 4 * r));
      tick();
    end

    // Dequeue without fetch takes count from 4 to 3
    imem_valid = 1'b0;
    #1;
    chk_head("pre3", 32'h14);
    tick();
    #1;
    chk("cnt3", 32'(count), 32'd3);
    chk_head("pre_redir", 32'h18);

    // Redirect discards the visible head and the ROM word
    redirect    = 1'b1;
    redirect_pc = 32'h8000_0007;
    imem_valid  = 1'b1;
    tick();
    redirect = 1'b0;
    #1;
    chk_bubble("redir_bub", 32'h8000_0000);
    chk("redir_addr", imem_addr, 32'h0000_0004);
    tick();
    #1;
    chk("redir_tgt_valid", 32'(deq_valid), 32'd1);
    chk("redir_tgt_pc",    deq_pc,         32'h8000_0004);
    chk("redir_tgt_pc4",   deq_pc4,        32'h8000_0008);
    chk("redir_tgt_ins",   deq_ins,        32'h2408_0004);

    // PC wrap at the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    #1;
    chk_bubble("wrap_bub", 32'h8000_0000);
    chk("wrap_addr", imem_addr, 32'h7FFF_FFFC);
    tick();
    #1;
    chk("wrap_pc0",  deq_pc,    32'hFFFF_FFFC);
    chk("wrap_pc40", deq_pc4,   32'h0000_0000);
    chk("wrap_ins0", deq_ins,   32'hA407_FFFC);
    chk("wrap_addr1", imem_addr, 32'h0000_0000);
    tick();
    #1;
    chk_head("wrap1", 32'h0000_0000);

    // imem_valid toggling: only valid cycles fetch
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect  = 1'b0;
    deq_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      imem_valid = (t % 2 == 0);
      #1;
      chk("tog_addr", imem_addr, (t < 2) ? 32'h100 + 32'(4 * t) : 32'h104 + 32'(4 * (t - 2)));
      tick();
    end
    imem_valid = 1'b0;
    deq_ready  = 1'b1;
    #1;
    chk("tog_count2", 32'(count), 32'd2);
    chk("tog_addr_hold", imem_addr, 32'h108);
    chk_head("tog_h0", 32'h100);
    tick();
    #1;
    chk_head("tog_h1", 32'h104);
    tick();
    #1;
    chk_bubble("tog_empty", 32'h0000_0000);

    // Asynchronous reset mid-cycle with an entry queued
    imem_valid = 1'b1;
    deq_ready  = 1'b0;
    tick();
    #1;
    chk("pre_rst_count", 32'(count), 32'd1);
    reset = 1'b0;
    #1;
    chk_bubble("async_rst", 32'h0000_0000);
    chk("async_rst_addr", imem_addr, 32'h0000_0000);
    tick();
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
